// File: rtl/uart_pkt_rx.sv
// Packet receiver for an RS-485 UART link: collects PKT_BYTES framed bytes after a
// start pulse, streaming each byte out with a write strobe and flagging success or abort.
module uart_pkt_rx #(
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned PKT_BYTES    = 20,
    parameter bit          PARITY_EN    = 1'b0,
    parameter int unsigned TIMEOUT_BITS = 64,
    localparam int unsigned AW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1
) (
    input  logic          clk80MHz,
    input  logic          rst,
    input  logic          start,
    input  logic          UART_RX,
    output logic          UART_dRX,
    output logic [7:0]    rx_data,
    output logic [AW-1:0] rx_addr,
    output logic          rx_we,
    output logic          ValRX,
    output logic          err,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int unsigned TW     = $clog2(CLK_DIV);
    localparam int unsigned TO_LIM = TIMEOUT_BITS * CLK_DIV;
    localparam int unsigned TOW    = (TO_LIM > 1) ? $clog2(TO_LIM) : 1;

    localparam logic [TW-1:0]  HALF_M1 = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1 = TW'(CLK_DIV - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_LIM - 1);
    localparam logic [AW-1:0]  LAST_IX = AW'(PKT_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t         state, state_nx;
    logic           rx_s1, rx_s2, rx_prev;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [AW-1:0]  cnt;
    logic [TOW-1:0] to_cnt;

    logic           tick, store, abort, accept, restart_timer, to_clr;
    logic [1:0]     abort_code;

    always_comb begin
        state_nx      = state;
        tick          = 1'b0;
        store         = 1'b0;
        abort         = 1'b0;
        abort_code    = 2'b00;
        accept        = 1'b0;
        restart_timer = 1'b0;
        to_clr        = 1'b0;

        case (state)
            START:              tick = (timer == HALF_M1);
            DATA, PARITY, STOP: tick = (timer == FULL_M1);
            default:            tick = 1'b0;
        endcase

        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    to_clr   = 1'b1;
                    state_nx = WAIT_START;
                end
            end
            WAIT_START: begin
                if (to_cnt == TO_LAST) begin
                    abort      = 1'b1;
                    abort_code = 2'b11;
                end else if (rx_prev && !rx_s2) begin
                    restart_timer = 1'b1;
                    state_nx      = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s2) begin
                        to_clr   = 1'b1;
                        state_nx = WAIT_START;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && bit_idx == 3'd7)
                    state_nx = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
                if (tick) begin
                    if ((^shreg) ^ rx_s2) begin
                        abort      = 1'b1;
                        abort_code = 2'b10;
                    end else begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rx_s2) begin
                        abort      = 1'b1;
                        abort_code = 2'b01;
                    end else begin
                        store  = 1'b1;
                        to_clr = 1'b1;
                        state_nx = (cnt == LAST_IX) ? DONE : WAIT_START;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (abort)
            state_nx = IDLE;
    end

    always_ff @(posedge clk80MHz) begin
        if (rst) begin
            state    <= IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            timer    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            cnt      <= '0;
            to_cnt   <= '0;
            rx_data  <= '0;
            rx_addr  <= '0;
            rx_we    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state   <= state_nx;
            rx_s1   <= UART_RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;

            // Timer free-runs outside bit states; every entry to START restarts it,
            // and each sample tick restarts it for the next bit.
            if (restart_timer || tick)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (state != DATA)
                bit_idx <= '0;
            else if (tick)
                bit_idx <= bit_idx + 1'b1;

            if (state == DATA && tick)
                shreg <= {rx_s2, shreg[7:1]};

            if (to_clr)
                to_cnt <= '0;
            else if (state == WAIT_START)
                to_cnt <= to_cnt + 1'b1;

            if (accept)
                cnt <= '0;
            else if (store)
                cnt <= cnt + 1'b1;

            rx_we <= store;
            if (store) begin
                rx_data <= shreg;
                rx_addr <= cnt;
            end

            err <= abort;
            if (accept)
                err_code <= 2'b00;
            else if (abort)
                err_code <= abort_code;
        end
    end

    assign busy     = (state == WAIT_START) || (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);
    assign UART_dRX = !busy;
    assign ValRX    = (state == DONE);

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Randomised bench for uart_pkt_rx: a frame-level event scoreboard for the default
// build plus a parity-enabled instance checked against computed even parity.
module tb_uart_pkt_rx;

    localparam int BIT = 16;
    localparam int NPK = 20;

    logic       clk = 1'b0;
    logic       rst, start, rx_line, UART_dRX, rx_we, ValRX, err, busy;
    logic [7:0] rx_data;
    logic [4:0] rx_addr;
    logic [1:0] err_code;

    logic       start_p, rx_line_p, dRX_p, p_we, p_val, p_err, busy_p;
    logic [7:0] p_data;
    logic [4:0] p_addr;
    logic [1:0] err_code_p;

    always #6 clk = ~clk;

    uart_pkt_rx dut (
        .clk80MHz(clk), .rst(rst), .start(start), .UART_RX(rx_line),
        .UART_dRX(UART_dRX), .rx_data(rx_data), .rx_addr(rx_addr), .rx_we(rx_we),
        .ValRX(ValRX), .err(err), .err_code(err_code), .busy(busy)
    );

    uart_pkt_rx #(.PARITY_EN(1'b1)) dut_p (
        .clk80MHz(clk), .rst(rst), .start(start_p), .UART_RX(rx_line_p),
        .UART_dRX(dRX_p), .rx_data(p_data), .rx_addr(p_addr), .rx_we(p_we),
        .ValRX(p_val), .err(p_err), .err_code(err_code_p), .busy(busy_p)
    );

    localparam int K_WE = 0, K_VAL = 1, K_ERR = 2;
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         addr;
        logic [1:0] code;
    } ev_t;

    ev_t        q[$];
    int         checks = 0, errors = 0;
    int         exp_cnt = 0;
    logic [7:0] last_data = '0;
    int         last_addr = 0;
    bit         hold_ok = 1'b0;
    int         n_we = 0, n_val = 0, n_err = 0;
    int         p_n_we = 0, p_n_err = 0;
    logic [7:0] p_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input int a, input logic [1:0] c);
        ev_t e;
        e.kind = kind; e.data = d; e.addr = a; e.code = c;
        q.push_back(e);
    endtask

    // Scoreboard: every strobe/pulse must be the next event the frame model predicted.
    always @(negedge clk) begin
        ev_t e;
        if (rx_we) begin
            chk("we_expected", 32'(q.size() > 0 && q[0].kind == K_WE), 32'd1);
            if (q.size() > 0 && q[0].kind == K_WE) begin
                e = q.pop_front();
                chk("we_data", 32'(rx_data), 32'(e.data));
                chk("we_addr", 32'(rx_addr), 32'(e.addr));
                last_data = e.data;
                last_addr = e.addr;
            end
            n_we++;
        end else if (hold_ok) begin
            chk("hold_data", 32'(rx_data), 32'(last_data));
            chk("hold_addr", 32'(rx_addr), 32'(last_addr));
        end
        if (ValRX) begin
            chk("val_expected", 32'(q.size() > 0 && q[0].kind == K_VAL), 32'd1);
            if (q.size() > 0 && q[0].kind == K_VAL) e = q.pop_front();
            n_val++;
        end
        if (err) begin
            chk("err_expected", 32'(q.size() > 0 && q[0].kind == K_ERR), 32'd1);
            if (q.size() > 0 && q[0].kind == K_ERR) begin
                e = q.pop_front();
                chk("err_code_at_err", 32'(err_code), 32'(e.code));
            end
            n_err++;
        end
        chk("val_err_excl", 32'(ValRX & err), 32'd0);
    end

    always @(negedge clk) begin
        if (p_we) begin
            p_n_we++;
            p_last = p_data;
        end
        if (p_err) p_n_err++;
        chk("p_val_err_excl", 32'(p_val & p_err), 32'd0);
    end

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line = bits[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        rx_line = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    // Model: a good stop bit yields a write at the next address; the last one completes the packet.
    task automatic frame(input logic [7:0] b, input logic stop);
        logic [10:0] f;
        if (stop) begin
            push(K_WE, b, exp_cnt, 2'b00);
            exp_cnt++;
            if (exp_cnt == NPK) push(K_VAL, 8'h00, 0, 2'b00);
        end else begin
            push(K_ERR, 8'h00, 0, 2'b01);
        end
        f = {1'b1, stop, b, 1'b0};
        send_bits(f, 10);
    endtask

    task automatic frame_p(input logic [7:0] b, input logic par);
        logic [10:0] f;
        f = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_line_p = f[i];
            repeat (BIT) @(negedge clk);
        end
        rx_line_p = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic pulse_start_p();
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
    endtask

    task automatic do_reset();
        hold_ok = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_data = '0;
        last_addr = 0;
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        hold_ok = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        int we0, val0, err0;
        logic [7:0] b;
        rst = 1'b1; start = 1'b0; rx_line = 1'b1; start_p = 1'b0; rx_line_p = 1'b1;
        do_reset();

        chk("rst_dRX", 32'(UART_dRX), 32'd1);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_addr", 32'(rx_addr), 32'd0);
        chk("rst_we", 32'(rx_we), 32'd0);
        chk("rst_val", 32'(ValRX), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Full packet 0,10,...,190 with 10 idle bits between frames
        we0 = n_we; val0 = n_val;
        pulse_start();
        @(negedge clk);
        chk("win_busy", 32'(busy), 32'd1);
        chk("win_dRX", 32'(UART_dRX), 32'd0);
        pulse_start();
        for (int i = 0; i < NPK; i++) begin
            idle_bits(i == 0 ? 2 : 10);
            if (i == 7) chk("mid_dRX", 32'(UART_dRX), 32'd0);
            frame(8'(i * 10), 1'b1);
        end
        drain("pkt1_drain");
        chk("pkt1_we_cnt", 32'(n_we - we0), 32'd20);
        chk("pkt1_val_cnt", 32'(n_val - val0), 32'd1);
        chk("pkt1_last_data", 32'(rx_data), 32'd190);
        chk("pkt1_last_addr", 32'(rx_addr), 32'd19);
        chk("pkt1_done_dRX", 32'(UART_dRX), 32'd1);
        chk("pkt1_done_busy", 32'(busy), 32'd0);

        // Random bytes, random short gaps including back-to-back frames
        pulse_start();
        for (int i = 0; i < NPK; i++) begin
            idle_bits(int'($urandom_range(0, 3)) + (i == 0 ? 1 : 0));
            frame(8'($urandom), 1'b1);
        end
        drain("pkt_rand_drain");

        // Framing error on byte 5
        idle_bits(2);
        we0 = n_we; val0 = n_val; err0 = n_err;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            idle_bits(2);
            frame(8'($urandom), i != 5);
        end
        drain("frm_drain");
        chk("frm_err_cnt", 32'(n_err - err0), 32'd1);
        chk("frm_code", 32'(err_code), 32'd1);
        chk("frm_we_cnt", 32'(n_we - we0), 32'd5);
        chk("frm_val_cnt", 32'(n_val - val0), 32'd0);
        chk("frm_dRX", 32'(UART_dRX), 32'd1);

        // Timeout with line held idle
        idle_bits(2);
        err0 = n_err;
        push(K_ERR, 8'h00, 0, 2'b11);
        pulse_start();
        repeat (64 * 16 + 4) @(negedge clk);
        chk("to_err_cnt", 32'(n_err - err0), 32'd1);
        chk("to_code", 32'(err_code), 32'd3);
        chk("to_busy", 32'(busy), 32'd0);
        drain("to_drain");

        // Glitch then a valid byte
        we0 = n_we; err0 = n_err;
        pulse_start();
        chk("code_cleared", 32'(err_code), 32'd0);
        idle_bits(2);
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        idle_bits(2);
        chk("glitch_no_we", 32'(n_we - we0), 32'd0);
        chk("glitch_no_err", 32'(n_err - err0), 32'd0);
        frame(8'hA5, 1'b1);
        drain("glitch_drain");
        chk("glitch_we", 32'(n_we - we0), 32'd1);
        chk("glitch_data", 32'(rx_data), 32'hA5);
        do_reset();

        // Reset during bit 4 of byte 2, then a fresh packet
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            idle_bits(2);
            frame(8'($urandom), 1'b1);
        end
        idle_bits(2);
        b = 8'($urandom);
        send_bits({1'b1, 1'b1, b, 1'b0}, 5);
        rx_line = b[4];
        repeat (6) @(negedge clk);
        chk("pre_rst_drain", 32'(q.size()), 32'd0);
        rx_line = 1'b1;
        we0 = n_we; val0 = n_val; err0 = n_err;
        do_reset();
        idle_bits(3);
        chk("rst_nothing", 32'(n_we - we0 + n_val - val0 + n_err - err0), 32'd0);
        chk("rst_mid_addr", 32'(rx_addr), 32'd0);
        pulse_start();
        for (int i = 0; i < NPK; i++) begin
            idle_bits(1);
            frame(8'($urandom), 1'b1);
        end
        drain("pkt_after_rst_drain");
        chk("rst_pkt_we", 32'(n_we - we0), 32'd20);
        chk("rst_pkt_val", 32'(n_val - val0), 32'd1);

        // Parity instance: 0x03 has even weight, so parity 1 is wrong and 0 is right
        pulse_start_p();
        repeat (2 * BIT) @(negedge clk);
        frame_p(8'h03, 1'b1);
        chk("par_err_cnt", 32'(p_n_err), 32'd1);
        chk("par_code", 32'(err_code_p), 32'd2);
        chk("par_we_none", 32'(p_n_we), 32'd0);
        chk("par_busy", 32'(busy_p), 32'd0);
        pulse_start_p();
        repeat (2 * BIT) @(negedge clk);
        frame_p(8'h03, 1'b0);
        chk("par_ok_we", 32'(p_n_we), 32'd1);
        chk("par_ok_data", 32'(p_last), 32'd3);
        chk("par_ok_code", 32'(err_code_p), 32'd0);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            repeat (BIT) @(negedge clk);
            frame_p(b, ^b);
            chk("par_rand_data", 32'(p_last), 32'(b));
            chk("par_rand_addr", 32'(p_addr), 32'(i + 1));
        end
        b = 8'($urandom);
        repeat (BIT) @(negedge clk);
        frame_p(b, ~(^b));
        chk("par_bad_err", 32'(p_n_err), 32'd2);
        chk("par_bad_we", 32'(p_n_we), 32'd5);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
